// File: rtl/divider_s_18bits_9bits_sequential_pkg.sv
// Shared widths and FSM encoding for the sequential 18/9 sign-selectable divider.
package divider_pkg;

  localparam int A_chop_size = 18;                  // dividend / quotient width, iteration count
  localparam int B_chop_size = 9;                   // divisor width
  localparam int rem_width   = B_chop_size + 1;     // remainder width
  localparam int cnt_width   = $clog2(A_chop_size); // step counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/divider_s_18bits_9bits_sequential_if.sv
// Operand / result handshake bundle between a requester and the divider.
interface divider_s_18bits_9bits_sequential_if;
  import divider_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [A_chop_size-1:0] a;
  logic [B_chop_size-1:0] b;
  logic                   a_sign;
  logic                   b_sign;
  logic                   out_valid;
  logic                   out_ready;
  logic [A_chop_size-1:0] q;
  logic [rem_width-1:0]   r;
  logic                   div_zero;
  logic                   overflow;

  // Requester side: presents operands, consumes results.
  modport master (
    output in_valid, a, b, a_sign, b_sign, out_ready,
    input  in_ready, out_valid, q, r, div_zero, overflow
  );

  // Divider side.
  modport slave (
    input  in_valid, a, b, a_sign, b_sign, out_ready,
    output in_ready, out_valid, q, r, div_zero, overflow
  );

endinterface

// File: rtl/divider_s_18bits_9bits_sequential_restoring_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor magnitude, keep the difference when it fits.
module divider_restoring_step
  import divider_pkg::*;
(
  input  logic [rem_width-1:0]   rem_i,
  input  logic                   bit_i,
  input  logic [B_chop_size-1:0] b_mag_i,
  output logic [rem_width-1:0]   rem_o,
  output logic                   q_bit_o
);

  logic [rem_width:0] shifted;
  logic [rem_width:0] b_ext;

  // Trial subtraction; the incoming remainder is always below |B|, so the
  // kept result fits back into rem_width bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    b_ext   = {2'b00, b_mag_i};
    q_bit_o = (shifted >= b_ext);
    rem_o   = q_bit_o ? rem_width'(shifted - b_ext) : rem_width'(shifted);
  end

endmodule

// File: rtl/divider_s_18bits_9bits_sequential.sv
// Iterative sign-selectable divider: 18-bit dividend / 9-bit divisor,
// one quotient bit per clock, quotient truncated toward zero.
module divider_s_18bits_9bits_sequential
  import divider_pkg::*;
(
  input logic clk,
  input logic reset,
  divider_s_18bits_9bits_sequential_if.slave bus
);

  localparam logic [A_chop_size-1:0] q_half = {1'b1, {(A_chop_size-1){1'b0}}};

  div_state_e             state_q, state_d;
  logic [A_chop_size-1:0] a_mag_q;     // dividend bits, refilled with quotient bits as they retire
  logic [B_chop_size-1:0] b_mag_q;
  logic [rem_width-1:0]   rem_q;
  logic [cnt_width-1:0]   count_q;
  logic                   neg_quo_q;
  logic                   neg_rem_q;
  logic                   signed_q;
  logic [A_chop_size-1:0] q_q;
  logic [rem_width-1:0]   r_q;
  logic                   div_zero_q;
  logic                   overflow_q;
  logic                   out_valid_q;

  logic                   accept;
  logic                   b_zero;
  logic                   a_neg;
  logic                   b_neg;
  logic [rem_width-1:0]   rem_next;
  logic                   q_bit;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign b_zero = (bus.b == '0);
  assign a_neg  = bus.a[A_chop_size-1] & bus.a_sign;
  assign b_neg  = bus.b[B_chop_size-1] & bus.b_sign;

  divider_restoring_step u_step (
    .rem_i   (rem_q),
    .bit_i   (a_mag_q[A_chop_size-1]),
    .b_mag_i (b_mag_q),
    .rem_o   (rem_next),
    .q_bit_o (q_bit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)              state_d = b_zero ? DONE : DIV;
      DIV:  if (count_q == '0)       state_d = FIX;
      FIX:                           state_d = DONE;
      DONE: if (bus.out_ready)       state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Operand capture, restoring iteration, sign fix-up and result registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the whole datapath is reset so a mid-operation reset leaves no stale result visible.
    if (!reset) begin
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      signed_q    <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          a_mag_q   <= a_neg ? -bus.a : bus.a;
          b_mag_q   <= b_neg ? -bus.b : bus.b;
          rem_q     <= '0;
          count_q   <= cnt_width'(A_chop_size - 1);
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          signed_q  <= bus.a_sign | bus.b_sign;
          if (b_zero) begin
            q_q         <= '1;
            r_q         <= bus.a[rem_width-1:0];
            div_zero_q  <= 1'b1;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DIV: begin
          a_mag_q <= {a_mag_q[A_chop_size-2:0], q_bit};
          rem_q   <= rem_next;
          count_q <= count_q - cnt_width'(1);
        end
        FIX: begin
          q_q         <= neg_quo_q ? -a_mag_q : a_mag_q;
          r_q         <= neg_rem_q ? -rem_q : rem_q;
          div_zero_q  <= 1'b0;
          overflow_q  <= signed_q && ((neg_quo_q && (a_mag_q > q_half)) ||
                                      (!neg_quo_q && (a_mag_q >= q_half)));
          out_valid_q <= 1'b1;
        end
        DONE: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_divider_s_18bits_9bits_sequential.sv
// Self-checking bench for the sequential 18/9 divider: directed corner cases
// plus randomized operands against an integer-arithmetic reference.
module tb_divider_s_18bits_9bits_sequential;
  import divider_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  divider_s_18bits_9bits_sequential_if bus();

  divider_s_18bits_9bits_sequential dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [17:0] q;
    logic [9:0]  r;
    logic        dz;
    logic        ov;
  } res_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (C-style truncation toward zero).
  function automatic res_t model(input logic [17:0] a, input logic [8:0] b,
                                 input logic as, input logic bs);
    res_t e;
    int   av, bv, qi, ri;
    av = as ? int'($signed(a)) : int'(a);
    bv = bs ? int'($signed(b)) : int'(b);
    if (bv == 0) begin
      e.q  = '1;
      e.r  = a[9:0];
      e.dz = 1'b1;
      e.ov = 1'b0;
    end else begin
      qi   = av / bv;
      ri   = av % bv;
      e.q  = qi[17:0];
      e.r  = ri[9:0];
      e.dz = 1'b0;
      e.ov = (as | bs) && (qi > 131071 || qi < -131072);
    end
    return e;
  endfunction

  // Issue one operation and check result and latency; result is left pending in DONE.
  task automatic run_op(input logic [17:0] a, input logic [8:0] b,
                        input logic as, input logic bs, input string tag);
    res_t e;
    int   k;
    int   guard;
    e = model(a, b, as, bs);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.a_sign = as; bus.b_sign = bs; bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "/latency"}, 32'(k), e.dz ? 32'd0 : 32'd19);
    @(negedge clk);
    check({tag, "/q"},        32'(bus.q),        32'(e.q));
    check({tag, "/r"},        32'(bus.r),        32'(e.r));
    check({tag, "/div_zero"}, 32'(bus.div_zero), 32'(e.dz));
    check({tag, "/overflow"}, 32'(bus.overflow), 32'(e.ov));
  endtask

  // Consume the pending result and confirm the divider returns to idle.
  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "/drop_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "/drop_ready"}, 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [17:0] ra;
    logic [8:0]  rb;
    logic        ras, rbs;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.a_sign = 1'b0; bus.b_sign = 1'b0;
    #12;
    check("rst/in_ready",  32'(bus.in_ready),  32'd1);
    check("rst/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst/q",         32'(bus.q),         32'd0);
    check("rst/r",         32'(bus.r),         32'd0);
    check("rst/flags",     32'({bus.div_zero, bus.overflow}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases with literal expectations alongside the model.
    run_op(18'd1000, 9'd7, 1'b0, 1'b0, "u1000_7");
    check("u1000_7/q_lit", 32'(bus.q), 32'd142);
    check("u1000_7/r_lit", 32'(bus.r), 32'd6);
    take("u1000_7");

    run_op(18'h3FC18, 9'd7, 1'b1, 1'b1, "sneg1000_7");
    check("sneg1000_7/q_lit", 32'(bus.q), 32'h3FF72);
    check("sneg1000_7/r_lit", 32'(bus.r), 32'h3FA);
    take("sneg1000_7");

    run_op(18'h3FC02, 9'h1FF, 1'b1, 1'b0, "mixed_511");
    check("mixed_511/q_lit", 32'(bus.q), 32'h3FFFE);
    check("mixed_511/r_lit", 32'(bus.r), 32'd0);
    take("mixed_511");

    run_op(18'd12345, 9'd0, 1'b0, 1'b0, "divzero");
    check("divzero/r_lit",  32'(bus.r),        32'd57);
    check("divzero/dz_lit", 32'(bus.div_zero), 32'd1);
    take("divzero");

    run_op(18'h20000, 9'h1FF, 1'b1, 1'b1, "ovf");
    check("ovf/q_lit",  32'(bus.q),        32'h20000);
    check("ovf/ov_lit", 32'(bus.overflow), 32'd1);
    take("ovf");

    // Result held while the consumer stalls.
    run_op(18'd54321, 9'd100, 1'b0, 1'b0, "stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall/q",         32'(bus.q),         32'd543);
      check("stall/r",         32'(bus.r),         32'd21);
      check("stall/out_valid", 32'(bus.out_valid), 32'd1);
      check("stall/in_ready",  32'(bus.in_ready),  32'd0);
    end
    take("stall");

    // Asynchronous reset in the middle of the DIV phase.
    @(negedge clk);
    bus.a = 18'd1000; bus.b = 9'd7; bus.a_sign = 1'b0; bus.b_sign = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst/out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst/in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst/q",         32'(bus.q),         32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(18'd1000, 9'd7, 1'b0, 1'b0, "after_rst");
    check("after_rst/q_lit", 32'(bus.q), 32'd142);
    take("after_rst");

    // Randomized operands and sign modes.
    for (int i = 0; i < 30; i++) begin
      ra  = 18'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
      ras = 1'($urandom);
      rbs = 1'($urandom);
      run_op(ra, rb, ras, rbs, $sformatf("rnd%0d", i));
      take($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider_s_18bits_9bits_sequential.md
# divider_S_18bits_9bits_sequential

Iterative signed/unsigned integer divider: the inverse of the team's 9x9 sign-selectable multiplier. It takes an 18-bit dividend (product width) and a 9-bit divisor, each with its own sign-interpretation bit. It returns an 18-bit quotient truncated toward zero, a 10-bit remainder and status flags. It sits beside the multiplier in the DSP datapath and retires one quotient bit per clock behind a valid/ready handshake.

## Interface
- A_chop_size, 18: dividend and quotient width; also the iteration count.
- B_chop_size, 9: divisor width; remainder width is B_chop_size+1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- in_valid  in  1  operands valid.
- in_ready  out  1  divider idle and able to accept.
- A  in  A_chop_size  dividend.
- B  in  B_chop_size  divisor.
- A_sign  in  1  treat A as two's complement.
- B_sign  in  1  treat B as two's complement.
- out_valid  out  1  result valid, held until taken.
- out_ready  in  1  consumer accepts result.
- Q  out  A_chop_size  quotient.
- R  out  B_chop_size+1  remainder, sign of dividend.
- div_zero  out  1  divisor was zero.
- overflow  out  1  quotient not representable.

## Operation
- States: IDLE, DIV, FIX, DONE. in_ready = (state==IDLE).
- IDLE, accept (in_valid&&in_ready):
  - Compute A_neg = A[msb]&A_sign and B_neg = B[msb]&B_sign.
  - Register the unsigned magnitudes |A| (18 b) and |B| (9 b), neg_q = A_neg^B_neg and neg_r = A_neg.
  - Clear the 10-bit partial remainder. Set count = A_chop_size-1.
  - Go to DIV.
- Divide by zero (B==0 at accept): skip DIV and go straight to DONE with Q = all ones, R = A[9:0] and div_zero=1.
- DIV, per cycle, one restoring step:
  - Shift the next dividend bit (MSB first) into the partial remainder.
  - If the partial remainder is at least |B|, subtract |B| and the quotient bit is 1; otherwise the quotient bit is 0.
  - Decrement count. After the step with count==0, go to FIX.
- FIX:
  - Q = neg_q ? -qmag : qmag, R = neg_r ? -rmag : rmag, both two's-complement truncated to width.
  - The result is signed when A_sign|B_sign.
  - overflow=1 when the result is signed and either (neg_q and qmag > 2^17) or (!neg_q and qmag >= 2^17). It is never set for an unsigned result.
  - Go to DONE.
- DONE: out_valid=1. Q, R and the flags are stable until out_valid&&out_ready, then go to IDLE. in_valid is ignored outside IDLE.
- Reset (asynchronous, at any point including mid-DIV):
  - State goes to IDLE and Q, R, out_valid, div_zero and overflow go to 0.
  - Internal magnitudes and count go to 0.
  - in_ready=1 while reset is held and after it is released.

## Timing
- Normal path: the accept edge is E0, DIV steps occupy E1..E18 and FIX is E19. out_valid rises after E19, so latency is 19 clocks.
- Divide-by-zero path: out_valid rises after E0, so latency is 1 clock.
- Result drop: on the edge where out_valid&&out_ready, out_valid falls and in_ready rises.
- Back-to-back: the next accept can occur on the edge after the drop. Throughput is 1 result per 21 clocks with out_ready held high.
- All outputs are registered except in_ready, which is decoded from state.

## Structure
- Package divider_pkg holds:
  - the state enum (IDLE, DIV, FIX, DONE);
  - the width constants (A_chop_size, B_chop_size, remainder width);
  - the count width, clog2(A_chop_size).
- Sub-module divider_restoring_step is combinational:
  - inputs: partial remainder, incoming dividend bit, |B|;
  - outputs: next remainder and quotient bit.
- The top level holds the FSM, counter, magnitude/sign registers and the FIX logic.

## Test plan
- A=18'd1000, B=9'd7, A_sign=B_sign=0 -> Q=18'd142, R=10'd6, flags 0, out_valid exactly 19 clocks after accept.
- A=18'h3FC18 (-1000), B=9'd7, A_sign=B_sign=1 -> Q=18'h3FF72 (-142), R=10'h3FA (-6).
- A=18'h3FC02 (-1022), B=9'h1FF, A_sign=1, B_sign=0 (B=511) -> Q=18'h3FFFE (-2), R=0.
- A=18'd12345, B=0 -> Q=18'h3FFFF, R=10'd57, div_zero=1, out_valid 1 clock after accept.
- A=18'h20000, B=9'h1FF, A_sign=B_sign=1 (-131072 / -1) -> Q=18'h20000, R=0, overflow=1.
- out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0. Next operation: drop reset at DIV step 10 -> out_valid=0 and in_ready=1 immediately; after release, a fresh 1000/7 completes correctly.
